// File: rtl/div_seq_pkg.sv
// Shared definitions for the iterative divider: op codes, FSM states and
// operand helpers used by div_seq and div_step.
package div_seq_pkg;

  localparam int unsigned DIV_W = 32;

  localparam logic [1:0] DIV_OP_DIV  = 2'd0;
  localparam logic [1:0] DIV_OP_DIVU = 2'd1;
  localparam logic [1:0] DIV_OP_REM  = 2'd2;
  localparam logic [1:0] DIV_OP_REMU = 2'd3;

  typedef enum logic [1:0] {
    DIV_ST_IDLE   = 2'd0,
    DIV_ST_RUN    = 2'd1,
    DIV_ST_FINISH = 2'd2
  } div_state_e;

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic is_rem_op(input logic [1:0] op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [DIV_W-1:0] abs32(input logic [DIV_W-1:0] v);
    return v[DIV_W-1] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division iteration.
module div_step
  import div_seq_pkg::*;
(
  input  logic [DIV_W:0]   i_rem,
  input  logic [DIV_W-1:0] i_quo,
  input  logic [DIV_W-1:0] i_divisor,
  output logic [DIV_W:0]   o_rem,
  output logic [DIV_W-1:0] o_quo
);

  logic [DIV_W+1:0] w_shift;
  logic [DIV_W+1:0] w_trial;
  logic             w_ge;

  // One extra bit of headroom keeps the borrow visible in w_trial's MSB.
  assign w_shift = {i_rem, i_quo[DIV_W-1]};
  assign w_trial = w_shift - {2'b00, i_divisor};
  assign w_ge    = ~w_trial[DIV_W+1];

  assign o_rem = w_ge ? w_trial[DIV_W:0] : w_shift[DIV_W:0];
  assign o_quo = {i_quo[DIV_W-2:0], w_ge};

endmodule

// File: rtl/div_seq.sv
// Iterative 32-bit DIV/DIVU/REM/REMU sequencer with stall and flush.
// Optional macro DIV_SPECIAL_FAST_EN: divide-by-zero and signed overflow skip the loop.
module div_seq
  import div_seq_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [DIV_W-1:0] i_dividend,
  input  logic [DIV_W-1:0] i_divisor,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_done,
  output logic [DIV_W-1:0] o_result
);

  div_state_e       r_state;
  logic [1:0]       r_op;
  logic [DIV_W-1:0] r_divisor;
  logic [DIV_W:0]   r_rem;
  logic [DIV_W-1:0] r_quo;
  logic [4:0]       r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_special;
  logic [DIV_W-1:0] r_spec_res;
  logic             r_busy;
  logic             r_done;
  logic [DIV_W-1:0] r_result;

  logic             w_signed;
  logic             w_div0;
  logic             w_ovf;
  logic [DIV_W-1:0] w_spec_res;
  logic [DIV_W:0]   w_rem_nxt;
  logic [DIV_W-1:0] w_quo_nxt;
  logic [DIV_W-1:0] w_q_out;
  logic [DIV_W-1:0] w_r_out;

  assign w_signed = is_signed_op(i_op);
  assign w_div0   = (i_divisor == '0);
  assign w_ovf    = w_signed && (i_dividend == 32'h8000_0000) && (i_divisor == 32'hFFFF_FFFF);

  // Architecturally mandated results, captured at start so FINISH can override.
  assign w_spec_res = is_rem_op(i_op) ? (w_div0 ? i_dividend : '0)
                                      : (w_div0 ? 32'hFFFF_FFFF : 32'h8000_0000);

  div_step u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_nxt),
    .o_quo     (w_quo_nxt)
  );

  assign w_q_out = r_neg_q ? (~r_quo + 32'd1) : r_quo;
  assign w_r_out = r_neg_r ? (~r_rem[DIV_W-1:0] + 32'd1) : r_rem[DIV_W-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= DIV_ST_IDLE;
      r_op       <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_cnt      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_special  <= 1'b0;
      r_spec_res <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_flush) begin
        r_state <= DIV_ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          DIV_ST_IDLE: begin
            r_busy <= 1'b0;
            if (i_start) begin
              r_op       <= i_op;
              r_divisor  <= w_signed ? abs32(i_divisor) : i_divisor;
              r_quo      <= w_signed ? abs32(i_dividend) : i_dividend;
              r_neg_q    <= w_signed & (i_dividend[DIV_W-1] ^ i_divisor[DIV_W-1]);
              r_neg_r    <= w_signed & i_dividend[DIV_W-1];
              r_rem      <= '0;
              r_cnt      <= '0;
              r_special  <= w_div0 | w_ovf;
              r_spec_res <= w_spec_res;
              r_busy     <= 1'b1;
`ifdef DIV_SPECIAL_FAST_EN
              r_state    <= (w_div0 | w_ovf) ? DIV_ST_FINISH : DIV_ST_RUN;
`else
              r_state    <= DIV_ST_RUN;
`endif
            end
          end
          DIV_ST_RUN: begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) r_state <= DIV_ST_FINISH;
          end
          DIV_ST_FINISH: begin
            // busy stays high through the done cycle; IDLE drops it afterwards.
            if (r_special)            r_result <= r_spec_res;
            else if (is_rem_op(r_op)) r_result <= w_r_out;
            else                      r_result <= w_q_out;
            r_done  <= 1'b1;
            r_state <= DIV_ST_IDLE;
          end
          default: r_state <= DIV_ST_IDLE;
        endcase
      end
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;

endmodule
